ahb_slave_pipe: RTL and testbench
=================================

# ahb_slave_pipe

Parametrised AHB slave front-end for the AHB-to-APB bridge. It qualifies AHB transfers, decodes the address into one of `NUM_SEL` equal-sized APB regions, and carries address, write data and direction through a `PIPE_DEPTH`-stage pipeline toward the APB controller. Unlike the fixed three-slave front-end, it adds the following:
- HTRANS qualification.
- Stall back-pressure via `HREADYout`.
- A two-cycle AHB ERROR response for unmapped, oversized or misaligned transfers.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (32 or 64).
- `NUM_SEL`, 3, number of APB select regions (1..8).
- `BASE_ADDR`, 32'h8000_0000, start of region 0 (inclusive).
- `REGION_SIZE`, 32'h0400_0000, size of each region; power of two.
- `PIPE_DEPTH`, 3, address/data pipeline stages (1..4).

Ports:
- `HCLK`  in  1  clock; all state on rising edge.
- `HRESETn`  in  1  reset; one clock, reset is asynchronous and active-low.
- `HADDR`  in  ADDR_W  AHB address.
- `HWDATA`  in  DATA_W  AHB write data (data phase).
- `HTRANS`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HWRITE`  in  1  1 = write.
- `HSIZE`  in  3  transfer size.
- `HREADYin`  in  1  bus-wide HREADY.
- `PRDATA`  in  DATA_W  read data from APB side.
- `apb_stall`  in  1  APB controller busy; stretch data phase.
- `HRDATA`  out  DATA_W  equals `PRDATA`, combinational.
- `HREADYout`  out  1  slave ready.
- `HRESP`  out  2  00 OKAY, 01 ERROR.
- `valid`  out  1  accepted, mapped, legal transfer this cycle (combinational).
- `TEMP_SEL`  out  NUM_SEL  one-hot region of `HADDR` (combinational), zero if unmapped.
- `sel_reg`  out  NUM_SEL  `TEMP_SEL` registered on acceptance.
- `HWRITEreg`  out  1  `HWRITE` registered on acceptance.
- `haddr_pipe`  out  PIPE_DEPTH*ADDR_W  stage k at bits [k*ADDR_W +: ADDR_W]; stage 0 is newest.
- `hwdata_pipe`  out  PIPE_DEPTH*DATA_W  same layout for write data.

## Operation
- **Active transfer:** `HTRANS` is NONSEQ or SEQ.
- **Acceptance:** `acc = HREADYin & active & (state==OKAY)`.
- **Mapped:** `BASE_ADDR <= HADDR < BASE_ADDR + NUM_SEL*REGION_SIZE`.
  - Region index = `(HADDR-BASE_ADDR)/REGION_SIZE`.
  - Both boundaries are exact: base is inclusive, top is exclusive.
- **Legal:**
  - `(8<<HSIZE) <= DATA_W`.
  - `HADDR` is aligned to `1<<HSIZE`.
- **valid:** `acc & mapped & legal`.
- **TEMP_SEL:** decodes regardless of `HTRANS`.
- **Error trigger:** `acc & ~(mapped & legal)` starts an error.

Error FSM, states `OKAY`, `ERR1`, `ERR2`:
- **OKAY:**
  - `HRESP=OKAY`.
  - `HREADYout = ~apb_stall`.
  - Goes to `ERR1` on error trigger.
- **ERR1:**
  - `HREADYout=0`, `HRESP=ERROR`.
  - Always goes to `ERR2`.
- **ERR2:**
  - `HREADYout=1`, `HRESP=ERROR`.
  - Always goes to `OKAY`.
  - Any transfer presented in ERR2 is not accepted. The master is required to cancel it.

Pipeline:
- **Shift condition:** `haddr_pipe` and `hwdata_pipe` shift only on edges where `HREADYin=1`, and hold otherwise.
- **Address stage 0** loads `HADDR` only when `valid`. Otherwise it holds, so IDLE/BUSY/error addresses never enter.
- **Data stage 0** loads `HWDATA` on the edge after a valid write address phase with `HREADYin=1`. This is the data-phase completion.
- **Registered outputs:** `sel_reg` and `HWRITEreg` load with address stage 0.
- **Stall with error:** `apb_stall` during an error sequence is ignored; the FSM has priority.

Reset values (asynchronous):
- State `OKAY`.
- `HREADYout=1`, `HRESP=OKAY`.
- All pipeline stages, `sel_reg`, `HWRITEreg` = 0.

`valid` is 0 while `HRESETn=0`. Reset asserted mid-ERR1/ERR2 returns to `OKAY` immediately.

## Timing
- `valid`, `TEMP_SEL` and `HRDATA` are zero-latency combinational.
- The accepted address appears in `haddr_pipe` stage 0 one edge after acceptance, and in stage k after k+1 shifting edges.
- Write data lags its address by exactly one shifting edge in stage indexing.
- The error response is exactly 2 cycles: `HREADYout` low for 1 cycle, then high for 1 cycle, with `HRESP=ERROR` throughout.
- A stall inserts one wait cycle per `apb_stall` cycle. There is no combinational path from `HADDR` to `HREADYout`.

## Structure
Shared package `ahb_pkg`:
- HTRANS encodings.
- HRESP encodings.
- Error FSM state enum.

Sub-module `ahb_addr_decode` is combinational: region index, one-hot select, and the mapped/legal flags. The FSM and pipeline stay in the top.

## Test plan
- **Reset:** `HRESETn=0` mid-ERR1 -> `HREADYout=1`, `HRESP=00` and all pipes 0 immediately, asynchronously.
- **Region boundaries (defaults):** check `TEMP_SEL` and `valid` at each address.
  - NONSEQ to 0x8000_0000 -> `TEMP_SEL=001`, `valid=1`.
  - 0x83FF_FFFC -> `001`.
  - 0x8400_0000 -> `010`.
  - 0x8BFF_FFFC -> `100`.
  - 0x8C00_0000 -> `000`, with the ERROR sequence.
- **Pipeline:** three back-to-back writes A1..A3 with data D1..D3, `HREADYin=1` -> after 3 edges, stages 2/1/0 hold A1/A2/A3. Data follows one edge later.
- **IDLE/BUSY:** IDLE or BUSY to 0x8000_0000 -> `valid=0`, no pipeline load, `HRESP=OKAY`.
- **Illegal size/alignment:** `HSIZE=3` at `DATA_W=32`, or `HSIZE=2` at 0x8000_0002 -> `HREADYout` 0 then 1, `HRESP=01` for both cycles, pipeline unchanged.
- **Stall:** `apb_stall=1` for 4 cycles during a write data phase -> `HREADYout=0` for exactly 4 cycles. `hwdata_pipe` loads on the first edge with `HREADYin=1`.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and error-response FSM states for the AHB-to-APB bridge
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    function automatic logic trans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational region decode plus size/alignment legality check
module ahb_addr_decode #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [2:0]         hsize,
    output logic [NUM_SEL-1:0] sel,
    output logic               mapped,
    output logic               legal
);

    localparam int RS_LOG2  = $clog2(REGION_SIZE);
    localparam int SEL_W    = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] region;
    logic              above_base;

    always_comb begin
        above_base = (haddr >= BASE_ADDR);
        offset     = haddr - BASE_ADDR;
        // Regions are power-of-two sized, so the index is a plain shift of the offset.
        region     = offset >> RS_LOG2;
        mapped     = above_base && (region < ADDR_W'(NUM_SEL));
        sel        = '0;
        if (mapped) begin
            sel[region[SEL_W-1:0]] = 1'b1;
        end
        legal = (int'(hsize) <= MAX_SIZE) &&
                ((haddr & ~({ADDR_W{1'b1}} << hsize)) == '0);
    end

endmodule

// File: rtl/ahb_slave_pipe.sv
// rtl/ahb_slave_pipe.sv - AHB slave front-end: transfer qualification, error response, addr/data pipeline
module ahb_slave_pipe
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000,
    parameter int                PIPE_DEPTH  = 3
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [DATA_W-1:0]            HWDATA,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic                         HREADYin,
    input  logic [DATA_W-1:0]            PRDATA,
    input  logic                         apb_stall,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADYout,
    output logic [1:0]                   HRESP,
    output logic                         valid,
    output logic [NUM_SEL-1:0]           TEMP_SEL,
    output logic [NUM_SEL-1:0]           sel_reg,
    output logic                         HWRITEreg,
    output logic [PIPE_DEPTH*ADDR_W-1:0] haddr_pipe,
    output logic [PIPE_DEPTH*DATA_W-1:0] hwdata_pipe
);

    err_state_e state, state_nxt;
    logic       mapped, legal, acc, err_trig;
    logic       wr_pend;

    ahb_addr_decode #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SEL     (NUM_SEL),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .haddr  (HADDR),
        .hsize  (HSIZE),
        .sel    (TEMP_SEL),
        .mapped (mapped),
        .legal  (legal)
    );

    always_comb begin
        acc      = HRESETn && HREADYin && trans_active(HTRANS) && (state == ST_OKAY);
        valid    = acc && mapped && legal;
        err_trig = acc && !(mapped && legal);
        HRDATA   = PRDATA;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_nxt;
        end
    end

    // The error sequence owns HREADYout; apb_stall only matters in OKAY.
    always_comb begin
        state_nxt = state;
        HREADYout = ~apb_stall;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_OKAY: begin
                if (err_trig) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                HREADYout = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HREADYout = 1'b1;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_OKAY;
            end
            default: state_nxt = ST_OKAY;
        endcase
        if (!HRESETn) begin
            HREADYout = 1'b1;
            HRESP     = HRESP_OKAY;
        end
    end

    // wr_pend marks that the next HREADYin edge completes a write data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_pipe  <= '0;
            hwdata_pipe <= '0;
            sel_reg     <= '0;
            HWRITEreg   <= 1'b0;
            wr_pend     <= 1'b0;
        end else if (HREADYin) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                haddr_pipe[k*ADDR_W +: ADDR_W]  <= haddr_pipe[(k-1)*ADDR_W +: ADDR_W];
                hwdata_pipe[k*DATA_W +: DATA_W] <= hwdata_pipe[(k-1)*DATA_W +: DATA_W];
            end
            if (valid) begin
                haddr_pipe[ADDR_W-1:0] <= HADDR;
                sel_reg                <= TEMP_SEL;
                HWRITEreg              <= HWRITE;
            end
            if (wr_pend) begin
                hwdata_pipe[DATA_W-1:0] <= HWDATA;
            end
            wr_pend <= valid && HWRITE;
        end
    end

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// tb/tb_ahb_slave_pipe.sv - scoreboard bench for ahb_slave_pipe against a cycle-level reference model
module tb_ahb_slave_pipe;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int PD = 3;
    localparam longint unsigned BASE = 64'h8000_0000;
    localparam longint unsigned RS   = 64'h0400_0000;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [AW-1:0]   HADDR;
    logic [DW-1:0]   HWDATA;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic            HREADYin;
    logic [DW-1:0]   PRDATA;
    logic            apb_stall;
    logic [DW-1:0]   HRDATA;
    logic            HREADYout;
    logic [1:0]      HRESP;
    logic            valid;
    logic [NS-1:0]   TEMP_SEL;
    logic [NS-1:0]   sel_reg;
    logic            HWRITEreg;
    logic [PD*AW-1:0] haddr_pipe;
    logic [PD*DW-1:0] hwdata_pipe;

    always #5 HCLK = ~HCLK;

    ahb_slave_pipe #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS),
        .BASE_ADDR(32'h8000_0000), .REGION_SIZE(32'h0400_0000), .PIPE_DEPTH(PD)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADYin(HREADYin),
        .PRDATA(PRDATA), .apb_stall(apb_stall), .HRDATA(HRDATA),
        .HREADYout(HREADYout), .HRESP(HRESP), .valid(valid), .TEMP_SEL(TEMP_SEL),
        .sel_reg(sel_reg), .HWRITEreg(HWRITEreg), .haddr_pipe(haddr_pipe),
        .hwdata_pipe(hwdata_pipe)
    );

    typedef struct {
        logic          v;
        logic [NS-1:0] ts;
        logic          rdy;
        logic [1:0]    resp;
        logic [DW-1:0] rd;
        logic [PD*AW-1:0] ap;
        logic [PD*DW-1:0] dp;
        logic [NS-1:0] sr;
        logic          hw;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: error cycles remaining, pipeline contents, pending write data phase.
    int          err_left;
    logic [31:0] m_a [PD];
    logic [31:0] m_d [PD];
    logic        m_pend;
    logic [NS-1:0] m_sel;
    logic        m_hw;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PD*32-1:0] pack(input logic [31:0] arr [PD]);
        logic [PD*32-1:0] p;
        for (int k = 0; k < PD; k++) p[k*32 +: 32] = arr[k];
        return p;
    endfunction

    task automatic model_reset();
        err_left = 0;
        for (int k = 0; k < PD; k++) begin
            m_a[k] = '0;
            m_d[k] = '0;
        end
        m_pend = 1'b0;
        m_sel  = '0;
        m_hw   = 1'b0;
    endtask

    task automatic set_idle();
        HTRANS = 2'b00; HADDR = '0; HSIZE = 3'd0; HWRITE = 1'b0; HWDATA = '0;
        apb_stall = 1'b0; HREADYin = 1'b1; PRDATA = '0;
    endtask

    task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                       input logic wr, input logic [31:0] wd, input logic st, input logic xr);
        exp_t e;
        longint unsigned a64;
        bit mapped, legal, acc, v, rdy;
        int region;
        logic [NS-1:0] ts;
        @(posedge HCLK);
        #1;
        rdy = (err_left == 0) ? !st : (err_left == 2) ? 1'b0 : 1'b1;
        HTRANS = tr; HADDR = a; HSIZE = sz; HWRITE = wr; HWDATA = wd;
        apb_stall = st; HREADYin = rdy & xr; PRDATA = $urandom;
        a64    = a;
        mapped = (a64 >= BASE) && (a64 < BASE + NS * RS);
        region = mapped ? int'((a64 - BASE) / RS) : 0;
        ts     = mapped ? NS'(1 << region) : '0;
        legal  = ((8 << sz) <= DW) && ((a % (32'd1 << sz)) == 0);
        acc    = HREADYin && (tr == 2'b10 || tr == 2'b11) && (err_left == 0);
        v      = acc && mapped && legal;
        e.v = v; e.ts = ts; e.rdy = rdy; e.resp = (err_left != 0) ? 2'b01 : 2'b00;
        e.rd = PRDATA; e.ap = pack(m_a); e.dp = pack(m_d); e.sr = m_sel; e.hw = m_hw;
        sbq.push_back(e);
        if (HREADYin) begin
            for (int k = PD - 1; k > 0; k--) begin
                m_a[k] = m_a[k-1];
                m_d[k] = m_d[k-1];
            end
            if (v) begin
                m_a[0] = a; m_sel = ts; m_hw = wr;
            end
            if (m_pend) m_d[0] = wd;
            m_pend = v && wr;
        end
        if (err_left > 0) err_left--;
        else if (acc && !(mapped && legal)) err_left = 2;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = 32'h7FFF_FF00 + ($urandom_range(0, 63) << 2);
            1: a = 32'h8C00_0000 + ($urandom_range(0, 63) << 2);
            default: a = 32'h8000_0000 + $urandom_range(0, 2) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
        endcase
        if ($urandom_range(0, 7) == 0) a = a ^ 32'h1;
        return a;
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(2'($urandom_range(0, 3)), rand_addr(),
                ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("valid", valid, e.v);
                chk("TEMP_SEL", TEMP_SEL, e.ts);
                chk("HREADYout", HREADYout, e.rdy);
                chk("HRESP", HRESP, e.resp);
                chk("HRDATA", HRDATA, e.rd);
                chk("haddr_pipe", haddr_pipe, e.ap);
                chk("hwdata_pipe", hwdata_pipe, e.dp);
                chk("sel_reg", sel_reg, e.sr);
                chk("HWRITEreg", HWRITEreg, e.hw);
            end
        end
    end

    initial begin : stim
        HRESETn = 1'b0;
        set_idle();
        model_reset();
        HTRANS = 2'b10; HADDR = 32'h8000_0000; HSIZE = 3'd2;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_HREADYout", HREADYout, 1'b1);
        chk("rst_HRESP", HRESP, 2'b00);
        chk("rst_haddr_pipe", haddr_pipe, '0);
        chk("rst_hwdata_pipe", hwdata_pipe, '0);
        chk("rst_sel_reg", sel_reg, '0);
        set_idle();
        HRESETn = 1'b1;

        // region boundaries, last one unmapped -> error sequence
        cyc(2'b10, 32'h8000_0000, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h83FF_FFFC, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h8400_0000, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h8BFF_FFFC, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h8C00_0000, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);

        // back-to-back writes
        cyc(2'b10, 32'h8000_0100, 3'd2, 1'b1, 32'h0,         1'b0, 1'b1);
        cyc(2'b11, 32'h8400_0104, 3'd2, 1'b1, 32'hD1D1_D1D1, 1'b0, 1'b1);
        cyc(2'b11, 32'h8800_0108, 3'd2, 1'b1, 32'hD2D2_D2D2, 1'b0, 1'b1);
        cyc(2'b00, 32'h0,         3'd0, 1'b0, 32'hD3D3_D3D3, 1'b0, 1'b1);
        cyc(2'b00, 32'h0,         3'd0, 1'b0, 32'h0,         1'b0, 1'b1);

        // IDLE and BUSY never load
        cyc(2'b00, 32'h8000_0000, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        cyc(2'b01, 32'h8000_0000, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1);

        // oversize, then misaligned
        cyc(2'b10, 32'h8000_0000, 3'd3, 1'b1, 32'h0, 1'b0, 1'b1);
        repeat (2) cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h8000_0002, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);

        // four-cycle stall in a write data phase
        cyc(2'b10, 32'h8000_0010, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        repeat (4) cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h5EED_F00D, 1'b1, 1'b1);
        cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h5EED_F00D, 1'b0, 1'b1);
        cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);

        rand_cycles(400);

        // asynchronous reset in the middle of ERR1
        cyc(2'b10, 32'h8000_0200, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        cyc(2'b10, 32'h8C00_0000, 3'd2, 1'b0, 32'hABCD_0123, 1'b0, 1'b1);
        @(posedge HCLK);
        #1;
        chk("err1_HREADYout", HREADYout, 1'b0);
        chk("err1_HRESP", HRESP, 2'b01);
        HTRANS = 2'b10; HADDR = 32'h8000_0000; HSIZE = 3'd2; HREADYin = 1'b1; apb_stall = 1'b1;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_HREADYout", HREADYout, 1'b1);
        chk("arst_HRESP", HRESP, 2'b00);
        chk("arst_haddr_pipe", haddr_pipe, '0);
        chk("arst_hwdata_pipe", hwdata_pipe, '0);
        chk("arst_sel_reg", sel_reg, '0);
        chk("arst_HWRITEreg", HWRITEreg, 1'b0);
        chk("arst_valid", valid, 1'b0);
        model_reset();
        set_idle();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        cyc(2'b10, 32'h8000_0000, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        rand_cycles(100);
        cyc(2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);

        repeat (2) @(negedge HCLK);
        chk("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
